ntt_round_scheduler: RTL and testbench

NTT_ROUND_SCHEDULER -- requirements
Module: ntt_round_scheduler

---
 rtl/ntt_pkg.sv | 59 +++++
 rtl/ntt_wb_delay.sv | 33 +++
 rtl/ntt_round_scheduler.sv | 175 +++++++++++++++++
 tb/tb_ntt_round_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and schedule lookups for the 8-point NTT round scheduler.
package ntt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int NTT_ROUNDS       = 5;
   localparam int NTT_BF_PER_ROUND = 4;

   // Butterfly span: 4 for rounds 0..2, 2 for round 3, 1 for round 4.
   function automatic logic [2:0] ntt_dist(input logic [2:0] rnd);
      case (rnd)
         3'd3:    ntt_dist = 3'd2;
         3'd4:    ntt_dist = 3'd1;
         default: ntt_dist = 3'd4;
      endcase
   endfunction

   // First twiddle index used by a round.
   function automatic logic [3:0] ntt_tw_base(input logic [2:0] rnd);
      case (rnd)
         3'd3:    ntt_tw_base = 4'd3;
         3'd4:    ntt_tw_base = 4'd5;
         default: ntt_tw_base = {1'b0, rnd};
      endcase
   endfunction

   // Lower operand address of butterfly k, chosen so that a+dist never overlaps another pair.
   function automatic logic [2:0] ntt_addr_a(input logic [2:0] rnd, input logic [1:0] k);
      case (ntt_dist(rnd))
         3'd2:    ntt_addr_a = {k[1], 1'b0, k[0]};
         3'd1:    ntt_addr_a = {k, 1'b0};
         default: ntt_addr_a = {1'b0, k};
      endcase
   endfunction

   // Twiddle ROM index: constant in early rounds, steps with k in the last two.
   function automatic logic [3:0] ntt_tw_addr(input logic [2:0] rnd, input logic [1:0] k);
      case (rnd)
         3'd3:    ntt_tw_addr = ntt_tw_base(rnd) + {3'b000, k[1]};
         3'd4:    ntt_tw_addr = ntt_tw_base(rnd) + {2'b00, k};
         default: ntt_tw_addr = ntt_tw_base(rnd);
      endcase
   endfunction

   // Operand source: the two inter-connect links first, then local BRAM.
   function automatic logic [1:0] ntt_sel(input logic [2:0] rnd);
      case (rnd)
         3'd0:    ntt_sel = 2'd1;
         3'd1:    ntt_sel = 2'd2;
         default: ntt_sel = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay: LAT-deep shift register carrying {en, addr_a, addr_b} from read issue to write-back.
module ntt_wb_delay #(
   parameter int LAT = 4
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       in_en,
   input  logic [2:0] in_addr_a,
   input  logic [2:0] in_addr_b,
   output logic       out_en,
   output logic [2:0] out_addr_a,
   output logic [2:0] out_addr_b
);

   logic [LAT-1:0][6:0] pipe_q;
   logic [LAT-1:0][6:0] pipe_d;

   // Shift one stage per cycle; stage 0 takes the freshly issued read.
   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = {in_en, in_addr_a, in_addr_b};
      for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
   end

   // Reset empties the line so in-flight writes are dropped.
   always_ff @(posedge clk) begin
      if (!rst_b) pipe_q <= '0;
      else        pipe_q <= pipe_d;
   end

   assign {out_en, out_addr_a, out_addr_b} = pipe_q[LAT-1];

endmodule

// File: rtl/ntt_round_scheduler.sv
// ntt_round_scheduler: runs 5 rounds x 4 butterflies over an 8-entry BRAM,
// draining LAT cycles between rounds so reads never race write-back.
// Build option NTT_SCHED_STALL_EN adds a stall input that freezes issue/drain.
module ntt_round_scheduler
   import ntt_pkg::*;
#(
   parameter int LAT = 4
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       start,
`ifdef NTT_SCHED_STALL_EN
   input  logic       stall,
`endif
   output logic       busy,
   output logic       done,
   output logic [2:0] round,
   output logic       rd_en,
   output logic [2:0] rd_addr_a,
   output logic [2:0] rd_addr_b,
   output logic [3:0] tw_addr,
   output logic [1:0] sel,
   output logic       wr_en,
   output logic [2:0] wr_addr_a,
   output logic [2:0] wr_addr_b
);

   logic stall_i;
`ifdef NTT_SCHED_STALL_EN
   assign stall_i = stall;
`else
   assign stall_i = 1'b0;
`endif

   state_e     state_q, state_d;
   logic [2:0] round_q, round_d;
   logic [1:0] k_q, k_d;
   logic [2:0] drain_q, drain_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       rd_en_q, rd_en_d;
   logic [2:0] rd_addr_a_q, rd_addr_a_d;
   logic [2:0] rd_addr_b_q, rd_addr_b_d;
   logic [3:0] tw_addr_q, tw_addr_d;
   logic [1:0] sel_q, sel_d;

   logic       issue;
   logic [2:0] issue_round;
   logic [1:0] issue_k;

   // Next state plus the registered-output values for the following cycle.
   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      k_d         = k_q;
      drain_d     = drain_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      rd_en_d     = 1'b0;
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      tw_addr_d   = tw_addr_q;
      sel_d       = sel_q;
      issue       = 1'b0;
      issue_round = round_q;
      issue_k     = k_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_ISSUE;
               round_d     = 3'd0;
               k_d         = 2'd0;
               busy_d      = 1'b1;
               issue       = 1'b1;
               issue_round = 3'd0;
               issue_k     = 2'd0;
            end
         end
         ST_ISSUE: begin
            if (!stall_i) begin
               if (k_q == 2'(NTT_BF_PER_ROUND - 1)) begin
                  state_d = ST_DRAIN;
                  drain_d = 3'd0;
               end else begin
                  k_d     = k_q + 2'd1;
                  issue   = 1'b1;
                  issue_k = k_q + 2'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (!stall_i) begin
               if (drain_q == 3'(LAT - 1)) begin
                  if (round_q == 3'(NTT_ROUNDS - 1)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d     = ST_ISSUE;
                     round_d     = round_q + 3'd1;
                     k_d         = 2'd0;
                     issue       = 1'b1;
                     issue_round = round_q + 3'd1;
                     issue_k     = 2'd0;
                  end
               end else begin
                  drain_d = drain_q + 3'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      // Addresses only move on an issue, so they hold while rd_en is low.
      if (issue) begin
         rd_en_d     = 1'b1;
         rd_addr_a_d = ntt_addr_a(issue_round, issue_k);
         rd_addr_b_d = ntt_addr_a(issue_round, issue_k) + ntt_dist(issue_round);
         tw_addr_d   = ntt_tw_addr(issue_round, issue_k);
         sel_d       = ntt_sel(issue_round);
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q     <= ST_IDLE;
         round_q     <= 3'd0;
         k_q         <= 2'd0;
         drain_q     <= 3'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_a_q <= 3'd0;
         rd_addr_b_q <= 3'd0;
         tw_addr_q   <= 4'd0;
         sel_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         k_q         <= k_d;
         drain_q     <= drain_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         tw_addr_q   <= tw_addr_d;
         sel_q       <= sel_d;
      end
   end

   ntt_wb_delay #(.LAT(LAT)) u_wb_delay (
      .clk       (clk),
      .rst_b     (rst_b),
      .in_en     (rd_en_q),
      .in_addr_a (rd_addr_a_q),
      .in_addr_b (rd_addr_b_q),
      .out_en    (wr_en),
      .out_addr_a(wr_addr_a),
      .out_addr_b(wr_addr_b)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign round     = round_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_addr_a_q;
   assign rd_addr_b = rd_addr_b_q;
   assign tw_addr   = tw_addr_q;
   assign sel       = sel_q;

endmodule

// File: tb/tb_ntt_round_scheduler.sv
// tb_ntt_round_scheduler: three schedulers (LAT 4, 1, 8) share stimulus and are
// checked every cycle against a timeline model derived from the schedule rules.
module tb_ntt_round_scheduler;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic start = 1'b0;
   logic stall = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [2:0] round;
      logic       rd_en;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [3:0] tw;
      logic [1:0] sel;
      logic       wr_en;
      logic [2:0] wa;
      logic [2:0] wb;
   } obs_t;

   logic       busy_w[NI], done_w[NI], rd_en_w[NI], wr_en_w[NI];
   logic [2:0] round_w[NI], ra_w[NI], rb_w[NI], wa_w[NI], wb_w[NI];
   logic [3:0] tw_w[NI];
   logic [1:0] sel_w[NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
      ntt_round_scheduler #(.LAT(L)) u_dut (
         .clk      (clk),
         .rst_b    (rst_b),
         .start    (start),
`ifdef NTT_SCHED_STALL_EN
         .stall    (stall),
`endif
         .busy     (busy_w[g]),
         .done     (done_w[g]),
         .round    (round_w[g]),
         .rd_en    (rd_en_w[g]),
         .rd_addr_a(ra_w[g]),
         .rd_addr_b(rb_w[g]),
         .tw_addr  (tw_w[g]),
         .sel      (sel_w[g]),
         .wr_en    (wr_en_w[g]),
         .wr_addr_a(wa_w[g]),
         .wr_addr_b(wb_w[g])
      );
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int launch[NI];
   logic [2:0] h_ra[NI], h_rb[NI];
   logic [3:0] h_tw[NI];
   obs_t exp_s[NI], obs_s[NI];

   // ---------------- reference model: schedule timeline arithmetic ----------------
   function automatic int lat_of(int i);
      return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
   endfunction

   function automatic int period(int i);
      return 4 + lat_of(i);
   endfunction

   // Is cycle t a read cycle of instance i's current run; which round / butterfly.
   function automatic bit read_at(int i, int t, output int r, output int k);
      int o;
      r = 0;
      k = 0;
      if (launch[i] < 0) return 1'b0;
      o = t - launch[i];
      if (o < 1 || o > 5 * period(i)) return 1'b0;
      r = (o - 1) / period(i);
      k = (o - 1) % period(i);
      return k < 4;
   endfunction

   function automatic logic [2:0] pair_a(int r, int k);
      if (r < 3) return 3'(k);
      if (r == 3) return 3'((k / 2) * 4 + k % 2);
      return 3'(2 * k);
   endfunction

   function automatic logic [2:0] pair_dist(int r);
      return (r < 3) ? 3'd4 : ((r == 3) ? 3'd2 : 3'd1);
   endfunction

   function automatic logic [3:0] tw_of(int r, int k);
      if (r < 3) return 4'(r);
      if (r == 3) return 4'(3 + k / 2);
      return 4'(5 + k);
   endfunction

   function automatic logic [1:0] sel_of(int r);
      return (r == 0) ? 2'd1 : ((r == 1) ? 2'd2 : 2'd3);
   endfunction

   // Advance one cycle: drive inputs for this cycle, sample mid-cycle, build
   // expected/observed records, then fold this cycle's inputs into the model.
   task automatic tick(input logic s, input logic rb_in, input logic st);
      int r, k, o, p;
      @(posedge clk);
      cyc++;
      #1;
      start = s;
      rst_b = rb_in;
      stall = st;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         obs_t e, ob;
         e  = '0;
         p  = period(i);
         o  = (launch[i] < 0) ? -1 : cyc - launch[i];
         e.busy = (o >= 1 && o <= 5 * p + 1);
         e.done = (o == 5 * p + 1);
         if (e.busy) begin
            e.round = 3'(((o - 1) / p > 4) ? 4 : (o - 1) / p);
            e.sel   = sel_of(int'(e.round));
         end
         if (read_at(i, cyc, r, k)) begin
            e.rd_en = 1'b1;
            h_ra[i] = pair_a(r, k);
            h_rb[i] = pair_a(r, k) + pair_dist(r);
            h_tw[i] = tw_of(r, k);
         end
         e.ra = h_ra[i];
         e.rb = h_rb[i];
         e.tw = h_tw[i];
         if (read_at(i, cyc - lat_of(i), r, k)) begin
            e.wr_en = 1'b1;
            e.wa    = pair_a(r, k);
            e.wb    = pair_a(r, k) + pair_dist(r);
         end
         ob = '{busy_w[i], done_w[i], round_w[i], rd_en_w[i], ra_w[i], rb_w[i],
                tw_w[i], sel_w[i], wr_en_w[i], wa_w[i], wb_w[i]};
         if (!e.busy) begin ob.round = '0; ob.sel = '0; end
         if (!e.wr_en) begin ob.wa = '0; ob.wb = '0; end
         exp_s[i] = e;
         obs_s[i] = ob;
         if (!rb_in) begin
            launch[i] = -1;
            h_ra[i] = '0; h_rb[i] = '0; h_tw[i] = '0;
         end else if (s && !e.busy) begin
            launch[i] = cyc;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int n = 0; n < 3; n++) tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < NI; i++) begin
         n_cmp++;
         if ({busy_w[i], done_w[i], rd_en_w[i], wr_en_w[i], round_w[i], ra_w[i], rb_w[i],
              tw_w[i], sel_w[i], wa_w[i], wb_w[i]} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_state lat=%0d got busy=%b done=%b rd=%b wr=%b sel=%0d ra=%0d tw=%0d want all 0",
                     lat_of(i), busy_w[i], done_w[i], rd_en_w[i], wr_en_w[i], sel_w[i], ra_w[i], tw_w[i]);
         end
      end
   endtask

   task automatic test_schedule();
      int c0;
      int done_at[NI];
      int want;
      for (int i = 0; i < NI; i++) done_at[i] = -1;
      for (int n = 0; n < int'($urandom_range(0, 3)); n++) tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      c0 = cyc;
      for (int n = 0; n < 70; n++) begin
         tick(1'b0, 1'b1, 1'b0);
         for (int i = 0; i < NI; i++) begin
            if (done_w[i] && done_at[i] < 0) done_at[i] = cyc - c0;
            n_cmp++;
            if (obs_s[i] !== exp_s[i]) begin
               n_bad++;
               $display("FAIL schedule lat=%0d rel=%0d got %h want %h", lat_of(i), cyc - c0, obs_s[i], exp_s[i]);
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         want = (i == 0) ? 41 : ((i == 1) ? 26 : 61);
         n_cmp++;
         if (done_at[i] != want) begin
            n_bad++;
            $display("FAIL done_cycle lat=%0d got %0d want %0d", lat_of(i), done_at[i], want);
         end
      end
   endtask

   task automatic test_ignore_start();
      int c0;
      tick(1'b1, 1'b1, 1'b0);
      c0 = cyc;
      for (int n = 1; n <= 110; n++) begin
         tick((n == 5 || n == 41), 1'b1, 1'b0);
         for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (obs_s[i] !== exp_s[i]) begin
               n_bad++;
               $display("FAIL ignore_start lat=%0d rel=%0d got %h want %h", lat_of(i), cyc - c0, obs_s[i], exp_s[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 200; n++) begin
         tick(n < 130, 1'b1, 1'b0);
         for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (obs_s[i] !== exp_s[i]) begin
               n_bad++;
               $display("FAIL back_to_back lat=%0d cyc=%0d got %h want %h", lat_of(i), cyc, obs_s[i], exp_s[i]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int c0;
      tick(1'b1, 1'b1, 1'b0);
      c0 = cyc;
      for (int n = 1; n <= 100; n++) begin
         tick((n == 20), (n != 14), 1'b0);
         if (n == 15) begin
            for (int i = 0; i < NI; i++) begin
               n_cmp++;
               if ({busy_w[i], done_w[i], rd_en_w[i], wr_en_w[i], round_w[i], ra_w[i], rb_w[i],
                    tw_w[i], sel_w[i], wa_w[i], wb_w[i]} !== 25'd0) begin
                  n_bad++;
                  $display("FAIL mid_reset_zero lat=%0d got busy=%b rd=%b wr=%b sel=%0d want all 0",
                           lat_of(i), busy_w[i], rd_en_w[i], wr_en_w[i], sel_w[i]);
               end
            end
         end
         for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (obs_s[i] !== exp_s[i]) begin
               n_bad++;
               $display("FAIL mid_reset lat=%0d rel=%0d got %h want %h", lat_of(i), cyc - c0, obs_s[i], exp_s[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic s, r;
      for (int n = 0; n < 470; n++) begin
         s = (n < 400) && ($urandom_range(0, 19) == 0);
         r = (n >= 400) || ($urandom_range(0, 149) != 0);
         tick(s, r, 1'b0);
         for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (obs_s[i] !== exp_s[i]) begin
               n_bad++;
               $display("FAIL random lat=%0d cyc=%0d got %h want %h", lat_of(i), cyc, obs_s[i], exp_s[i]);
            end
         end
      end
   endtask

`ifdef NTT_SCHED_STALL_EN
   // Stall is seen at the three edges that would launch k=1..3 of round 0;
   // everything after k=0 slips by 3 cycles while k=0's write stays put.
   task automatic test_stall();
      int c0, rr, kk, sh;
      logic e_rd, e_wr, e_done;
      logic [2:0] e_ra;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      c0 = cyc;
      for (int n = 1; n <= 50; n++) begin
         tick(1'b0, 1'b1, (n >= 1 && n <= 3));
         // unstalled timeline position of this cycle
         sh = (n >= 5) ? n - 3 : ((n == 1) ? 1 : 0);
         e_rd = 1'b0;
         e_ra = 3'd0;
         if (sh >= 1 && sh <= 40 && (sh - 1) % 8 < 4) begin
            rr = (sh - 1) / 8;
            kk = (sh - 1) % 8;
            e_rd = 1'b1;
            e_ra = pair_a(rr, kk);
         end
         e_wr   = (n == 5) || (n >= 9 && (n - 7) >= 1 && (n - 7) <= 40 && (n - 8) % 8 < 4);
         e_done = (n == 44);
         n_cmp++;
         if ({rd_en_w[0], wr_en_w[0], done_w[0]} !== {e_rd, e_wr, e_done} ||
             (e_rd && ra_w[0] !== e_ra)) begin
            n_bad++;
            $display("FAIL stall rel=%0d got rd=%b wr=%b done=%b ra=%0d want rd=%b wr=%b done=%b ra=%0d",
                     n, rd_en_w[0], wr_en_w[0], done_w[0], ra_w[0], e_rd, e_wr, e_done, e_ra);
         end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < NI; i++) begin
         launch[i] = -1;
         h_ra[i] = '0; h_rb[i] = '0; h_tw[i] = '0;
      end
      test_reset();
      test_schedule();
      test_ignore_start();
      test_back_to_back();
      test_mid_reset();
      test_random();
`ifdef NTT_SCHED_STALL_EN
      test_stall();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
